// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store memory responder with configurable access latency and byte lanes.
// Optional feature macro: MEM_BACK2BACK_EN (accept the next request in the response-handshake cycle).
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_format,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic        we_reg;
    logic [1:0]  format_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    logic        err_reg;
    logic        rsp_we_reg;
    logic [1:0]  rsp_format_reg;
    logic [1:0]  rsp_lane_reg;

    logic        accept;
    logic        commit;
    logic        write_en;

    logic        c_we;
    logic [1:0]  c_format;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] c_offset;
    logic [1:0]  c_lane;
    logic [ADDR_WIDTH-1:0] c_index;
    logic        c_err;
    logic [3:0]  c_be;
    logic [31:0] c_wword;
    logic [31:0] rd_word;

    always_comb begin
        req_ready = 1'b0;
        if (rst) begin
            if (state_reg == IDLE) begin
                req_ready = 1'b1;
            end
`ifdef MEM_BACK2BACK_EN
            if (state_reg == RESP) begin
                req_ready = rsp_ready;
            end
`endif
        end
    end

    assign accept = req_valid && req_ready;

    // With single-cycle latency the commit happens on the accept edge, straight from the request port.
    assign c_we     = (LATENCY == 1) ? req_we     : we_reg;
    assign c_format = (LATENCY == 1) ? req_format : format_reg;
    assign c_addr   = (LATENCY == 1) ? req_addr   : addr_reg;
    assign c_wdata  = (LATENCY == 1) ? req_wdata  : wdata_reg;
    assign commit   = (LATENCY == 1) ? accept
                                     : (rst && (state_reg == WAIT) && (cnt_reg <= 4'd1));

    assign c_offset = c_addr - BASE_ADDR;
    assign c_lane   = c_offset[1:0];
    assign c_index  = c_offset[ADDR_WIDTH+1:2];

    always_comb begin
        c_err = 1'b0;
        if (c_addr < BASE_ADDR) begin
            c_err = 1'b1;
        end
        if ((c_offset >> (ADDR_WIDTH + 2)) != 32'd0) begin
            c_err = 1'b1;
        end
        case (c_format)
            2'b01:   if (c_lane[0]) c_err = 1'b1;
            2'b10:   if (c_lane != 2'b00) c_err = 1'b1;
            2'b11:   c_err = 1'b1;
            default: ;
        endcase
    end

    // Store data is replicated across lanes so each lane RAM just picks its own byte.
    always_comb begin
        c_be    = 4'b0000;
        c_wword = c_wdata;
        case (c_format)
            2'b00: begin
                c_be    = 4'b0001 << c_lane;
                c_wword = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                c_be    = c_lane[1] ? 4'b1100 : 4'b0011;
                c_wword = {2{c_wdata[15:0]}};
            end
            2'b10:   c_be = 4'b1111;
            default: ;
        endcase
    end

    assign write_en = commit && c_we && !c_err;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            logic [7:0] ram [DEPTH];
            logic [7:0] rd_reg;
            always_ff @(posedge clk) begin
                if (commit) begin
                    if (write_en && c_be[gi]) begin
                        ram[c_index] <= c_wword[8*gi +: 8];
                    end
                    rd_reg <= ram[c_index];
                end
            end
            assign rd_word[8*gi +: 8] = rd_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                    if (accept) begin
                        state_next = (LATENCY == 1) ? RESP : WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            we_reg         <= 1'b0;
            format_reg     <= 2'b00;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            err_reg        <= 1'b0;
            rsp_we_reg     <= 1'b0;
            rsp_format_reg <= 2'b00;
            rsp_lane_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg     <= req_we;
                format_reg <= req_format;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
            end
            if (commit) begin
                err_reg        <= c_err;
                rsp_we_reg     <= c_we;
                rsp_format_reg <= c_format;
                rsp_lane_reg   <= c_lane;
            end
        end
    end

    always_comb begin
        rsp_valid = (state_reg == RESP);
        rsp_err   = rsp_valid && err_reg;
        rsp_rdata = 32'd0;
        if (rsp_valid && !err_reg && !rsp_we_reg) begin
            case (rsp_format_reg)
                2'b00: begin
                    case (rsp_lane_reg)
                        2'd0:    rsp_rdata = {24'd0, rd_word[7:0]};
                        2'd1:    rsp_rdata = {24'd0, rd_word[15:8]};
                        2'd2:    rsp_rdata = {24'd0, rd_word[23:16]};
                        default: rsp_rdata = {24'd0, rd_word[31:24]};
                    endcase
                end
                2'b01:   rsp_rdata = {16'd0, (rsp_lane_reg[1] ? rd_word[31:16] : rd_word[15:0])};
                default: rsp_rdata = rd_word;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses queued at request time, checked on rsp_valid.
module tb_data_mem_responder;
    localparam int LAT = 2;
`ifdef MEM_BACK2BACK_EN
    localparam logic EXP_RR_IN_RESP = 1'b1;
    localparam int   EXP_GAP        = LAT;
`else
    localparam logic EXP_RR_IN_RESP = 1'b0;
    localparam int   EXP_GAP        = LAT + 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_format = 2'b00;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    data_mem_responder #(
        .ADDR_WIDTH(12),
        .LATENCY(LAT),
        .BASE_ADDR(32'h8000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_format(req_format),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with rsp_ready held high.
    task automatic do_req(input logic we, input logic [1:0] fmt, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        int   wait_cyc;
        int   lat;
        exp_t e;
        e = {exp_rdata, exp_err};
        sb.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_format = fmt;
        req_addr   = addr;
        req_wdata  = wdata;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout addr=%08h req_ready=%b required 1", addr, req_ready);
            req_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL latency addr=%08h got %0d cycles required %0d", addr, lat, LAT);
        end
        if (rsp_valid !== 1'b1) begin
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL rdata addr=%08h got %08h required %08h", addr, rsp_rdata, e.rdata);
        end
        checks++;
        if (rsp_err !== e.err) begin
            errors++;
            $display("FAIL err addr=%08h got %b required %b", addr, rsp_err, e.err);
        end
        checks++;
        if (req_ready !== EXP_RR_IN_RESP) begin
            errors++;
            $display("FAIL req_ready_in_resp got %b required %b", req_ready, EXP_RR_IN_RESP);
        end
        $display("txn we=%0b fmt=%0d addr=%08h wdata=%08h rdata=%08h err=%0b lat=%0d",
                 we, fmt, addr, wdata, rsp_rdata, rsp_err, lat);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b required 0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got %08h required 0", rsp_rdata); end
        checks++;
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b required 0", rsp_err); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b required 0", req_ready); end
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b required 1", req_ready); end
        $display("txn reset released");
    endtask

    task automatic test_word_store_load();
        do_req(1'b1, 2'b10, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_byte_lanes();
        do_req(1'b1, 2'b10, 32'h8000_0010, 32'h1122_3344, 32'h0, 1'b0);
        do_req(1'b1, 2'b00, 32'h8000_0011, 32'hFFFF_FF5A, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'h1122_5A44, 1'b0);
        do_req(1'b0, 2'b00, 32'h8000_0011, 32'h0, 32'h0000_005A, 1'b0);
        do_req(1'b0, 2'b01, 32'h8000_0012, 32'h0, 32'h0000_1122, 1'b0);
        do_req(1'b0, 2'b00, 32'h8000_0013, 32'h0, 32'h0000_0011, 1'b0);
        do_req(1'b0, 2'b01, 32'h8000_0010, 32'h0, 32'h0000_5A44, 1'b0);
        do_req(1'b1, 2'b01, 32'h8000_0012, 32'hFFFF_BEEF, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'hBEEF_5A44, 1'b0);
        // Build a word one byte lane at a time.
        do_req(1'b1, 2'b10, 32'h8000_0200, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 2'b00, 32'h8000_0200 + 32'(i), 32'(8'h10 + i), 32'h0, 1'b0);
        end
        do_req(1'b0, 2'b10, 32'h8000_0200, 32'h0, 32'h1312_1110, 1'b0);
    endtask

    task automatic test_misaligned();
        do_req(1'b1, 2'b10, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, 1'b0);
        do_req(1'b0, 2'b01, 32'h8000_0013, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 2'b10, 32'h8000_0002, 32'h1234_5678, 32'h0, 1'b1);
        do_req(1'b0, 2'b10, 32'h8000_0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        do_req(1'b1, 2'b01, 32'h8000_0001, 32'h0000_9999, 32'h0, 1'b1);
        do_req(1'b0, 2'b10, 32'h8000_0000, 32'h0, 32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_range_format();
        do_req(1'b0, 2'b10, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);
        do_req(1'b0, 2'b10, 32'h8000_4000, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 2'b10, 32'h8000_3FFC, 32'hA5A5_5A5A, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 32'h8000_3FFC, 32'h0, 32'hA5A5_5A5A, 1'b0);
        do_req(1'b0, 2'b11, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 2'b11, 32'h8000_0000, 32'h0BAD_0BAD, 32'h0, 1'b1);
        do_req(1'b0, 2'b10, 32'h8000_0000, 32'h0, 32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        e = {32'hBEEF_5A44, 1'b0};
        sb.push_back(e);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_format = 2'b10;
        req_addr   = 32'h8000_0010;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got req_ready=%b required 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        // Intruding store must be ignored while the response is stalled.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got %b required 1", i, rsp_valid); end
            checks++;
            if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL bp_rdata cyc=%0d got %08h required %08h", i, rsp_rdata, e.rdata); end
            checks++;
            if (rsp_err !== e.err) begin errors++; $display("FAIL bp_err cyc=%0d got %b required %b", i, rsp_err, e.err); end
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc=%0d got %b required 0", i, req_ready); end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        $display("txn we=0 fmt=2 addr=80000010 stalled 5 cycles rdata=%08h err=%0b", rsp_rdata, rsp_err);
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got rsp_valid=%b required 0", rsp_valid); end
        do_req(1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'hBEEF_5A44, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        do_req(1'b1, 2'b10, 32'h8000_0020, 32'h0102_0304, 32'h0, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_format = 2'b10;
        req_addr   = 32'h8000_0020;
        req_wdata  = 32'h9999_9999;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rw_accept got req_ready=%b required 1", req_ready); end
        tick();
        req_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_rsp_valid got %b required 0", rsp_valid); end
        rst = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_after_release got rsp_valid=%b required 0", rsp_valid); end
        $display("txn we=1 fmt=2 addr=80000020 wdata=99999999 aborted by reset");
        do_req(1'b0, 2'b10, 32'h8000_0020, 32'h0, 32'h0102_0304, 1'b0);
    endtask

    task automatic test_back_to_back();
        int   accepts = 0;
        int   resps = 0;
        int   rsp_cyc0 = 0;
        int   rsp_cyc1 = 0;
        logic acc_now;
        exp_t e;
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_format = 2'b10;
        req_addr   = 32'h8000_0010;
        for (int cyc = 0; cyc < 30 && resps < 2; cyc++) begin
            if (rsp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected_rsp cyc=%0d rdata=%08h required no response", cyc, rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL b2b_rsp cyc=%0d got %08h/%b required %08h/%b", cyc, rsp_rdata, rsp_err, e.rdata, e.err);
                    end
                end
                $display("txn b2b load addr=80000010 rdata=%08h err=%0b cyc=%0d", rsp_rdata, rsp_err, cyc);
                if (resps == 0) rsp_cyc0 = cyc;
                else rsp_cyc1 = cyc;
                resps++;
            end
            acc_now = req_valid && req_ready;
            if (acc_now) begin
                e = {32'hBEEF_5A44, 1'b0};
                sb.push_back(e);
            end
            tick();
            if (acc_now) begin
                accepts++;
                if (accepts == 2) req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        tick();
        checks++;
        if (resps !== 2) begin errors++; $display("FAIL b2b_count got %0d responses required 2", resps); end
        checks++;
        if (rsp_cyc1 - rsp_cyc0 !== EXP_GAP) begin
            errors++;
            $display("FAIL b2b_gap got %0d cycles required %0d", rsp_cyc1 - rsp_cyc0, EXP_GAP);
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_lanes();
        test_misaligned();
        test_range_format();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
